forward_scoreboard: RTL and testbench

- Parametrised successor to the EX-stage forwarding logic.
- Tracks destination tags of in-flight instructions in a shift-register scoreboard of configurable depth.
- For each decode-stage source operand it resolves the youngest producer, and detects load-use hazards requiring a one-cycle bubble.
- Forward selects are registered at decode, so they arrive aligned with the consuming instruction's EX cycle.

---
 rtl/forward_scoreboard.sv | 100 ++++++++++
 tb/tb_forward_scoreboard.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/forward_scoreboard.sv
// Shift-register scoreboard of in-flight destination tags. Resolves the youngest
// producer for each decode source operand and flags load-use hazards.
module forward_scoreboard #(
  parameter int REG_W        = 3,
  parameter int NUM_SRC      = 3,
  parameter int DEPTH        = 3,
  parameter int LOAD_READY   = 2,
  parameter int FLUSH_STAGES = 1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   advance,
  input  logic                                   flush,
  input  logic                                   issue_valid,
  input  logic                                   issue_regwrite,
  input  logic                                   issue_is_load,
  input  logic [REG_W-1:0]                       issue_dr,
  input  logic [NUM_SRC-1:0]                     src_valid,
  input  logic [NUM_SRC*REG_W-1:0]               src_reg,
  output logic [NUM_SRC*$clog2(DEPTH+1)-1:0]     fwd_sel,
  output logic                                   load_use_stall,
  output logic [$clog2(DEPTH+1)-1:0]             inflight,
  output logic [15:0]                            stall_count
);

  localparam int SEL_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0] ent_valid;
  logic [DEPTH-1:0] ent_regwrite;
  logic [DEPTH-1:0] ent_is_load;
  logic [REG_W-1:0] ent_dr [DEPTH];

  logic [SEL_W-1:0]   cand_sel [NUM_SRC];
  logic [NUM_SRC-1:0] src_hazard;

  // Scan oldest to youngest so the youngest matching producer is the last write.
  always_comb begin
    for (int s = 0; s < NUM_SRC; s++) begin
      cand_sel[s]   = '0;
      src_hazard[s] = 1'b0;
      for (int i = DEPTH-1; i >= 0; i--) begin
        if (src_valid[s] && ent_valid[i] && ent_regwrite[i] &&
            (ent_dr[i] == src_reg[s*REG_W +: REG_W])) begin
          cand_sel[s]   = SEL_W'(i + 1);
          src_hazard[s] = ent_is_load[i] && ((i + 1) < LOAD_READY);
        end
      end
    end
  end

  assign load_use_stall = |src_hazard;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && ent_regwrite[i]) inflight = inflight + SEL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ent_valid    <= '0;
      ent_regwrite <= '0;
      ent_is_load  <= '0;
      for (int i = 0; i < DEPTH; i++) ent_dr[i] <= '0;
      fwd_sel      <= '0;
      stall_count  <= '0;
    end else if (advance) begin
      for (int i = DEPTH-1; i > 0; i--) begin
        ent_valid[i]    <= ent_valid[i-1];
        ent_regwrite[i] <= ent_regwrite[i-1];
        ent_is_load[i]  <= ent_is_load[i-1];
        ent_dr[i]       <= ent_dr[i-1];
      end
      // A flushed or stalled decode slot enters the pipe as a bubble.
      if (flush || load_use_stall) begin
        ent_valid[0]    <= 1'b0;
        ent_regwrite[0] <= 1'b0;
        ent_is_load[0]  <= 1'b0;
        ent_dr[0]       <= '0;
      end else begin
        ent_valid[0]    <= issue_valid;
        ent_regwrite[0] <= issue_regwrite;
        ent_is_load[0]  <= issue_is_load;
        ent_dr[0]       <= issue_dr;
      end
      if (flush) begin
        for (int i = 1; i < FLUSH_STAGES; i++) begin
          if (i < DEPTH) ent_valid[i] <= 1'b0;
        end
      end
      for (int s = 0; s < NUM_SRC; s++) begin
        fwd_sel[s*SEL_W +: SEL_W] <= (flush || load_use_stall) ? '0 : cand_sel[s];
      end
      if (load_use_stall && !flush && (stall_count != 16'hFFFF))
        stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_forward_scoreboard.sv
// Bench for forward_scoreboard: directed vector table, a mid-stream reset
// sequence, then random traffic against a queue-based reference model.
module tb_forward_scoreboard;

  localparam int REG_W = 3, NUM_SRC = 3, DEPTH = 3, LOAD_READY = 2, FLUSH_STAGES = 1;
  localparam int SEL_W = 2;

  logic clk = 1'b0;
  logic reset, advance, flush, issue_valid, issue_regwrite, issue_is_load;
  logic [REG_W-1:0] issue_dr;
  logic [NUM_SRC-1:0] src_valid;
  logic [NUM_SRC*REG_W-1:0] src_reg;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel;
  logic load_use_stall;
  logic [SEL_W-1:0] inflight;
  logic [15:0] stall_count;

  int checks = 0;
  int failures = 0;

  forward_scoreboard #(.REG_W(REG_W), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH),
                       .LOAD_READY(LOAD_READY), .FLUSH_STAGES(FLUSH_STAGES)) dut (
    .clk(clk), .reset(reset), .advance(advance), .flush(flush),
    .issue_valid(issue_valid), .issue_regwrite(issue_regwrite),
    .issue_is_load(issue_is_load), .issue_dr(issue_dr),
    .src_valid(src_valid), .src_reg(src_reg), .fwd_sel(fwd_sel),
    .load_use_stall(load_use_stall), .inflight(inflight), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference model: youngest-first queue of in-flight instructions.
  typedef struct { bit v; bit rw; bit ld; int dr; } ent_t;
  ent_t pipe[$];
  int   m_cnt;
  int   m_fwd [NUM_SRC];
  int   m_sel [NUM_SRC];
  bit   m_stall;

  function automatic void m_eval();
    m_stall = 0;
    for (int s = 0; s < NUM_SRC; s++) begin
      m_sel[s] = 0;
      if (src_valid[s]) begin
        for (int i = 0; i < pipe.size(); i++) begin
          if (pipe[i].v && pipe[i].rw && pipe[i].dr == int'(src_reg[s*REG_W +: REG_W])) begin
            m_sel[s] = i + 1;
            if (pipe[i].ld && (i + 1) < LOAD_READY) m_stall = 1;
            break;
          end
        end
      end
    end
  endfunction

  function automatic int m_inflight();
    int n = 0;
    foreach (pipe[i]) if (pipe[i].v && pipe[i].rw) n++;
    return n;
  endfunction

  function automatic int m_fwd_packed();
    int p = 0;
    for (int s = 0; s < NUM_SRC; s++) p = p | (m_fwd[s] << (s * SEL_W));
    return p;
  endfunction

  function automatic void m_step();
    ent_t n;
    if (reset) begin
      pipe.delete();
      n = '{v: 0, rw: 0, ld: 0, dr: 0};
      for (int i = 0; i < DEPTH; i++) pipe.push_back(n);
      m_cnt = 0;
      for (int s = 0; s < NUM_SRC; s++) m_fwd[s] = 0;
    end else if (advance) begin
      m_eval();
      if (flush || m_stall) n = '{v: 0, rw: 0, ld: 0, dr: 0};
      else n = '{v: issue_valid, rw: issue_regwrite, ld: issue_is_load, dr: int'(issue_dr)};
      pipe.push_front(n);
      void'(pipe.pop_back());
      if (flush) for (int i = 0; i < FLUSH_STAGES; i++) pipe[i].v = 0;
      for (int s = 0; s < NUM_SRC; s++) m_fwd[s] = (flush || m_stall) ? 0 : m_sel[s];
      if (m_stall && !flush && m_cnt < 65535) m_cnt++;
    end
  endfunction

  typedef struct {
    bit rst, adv, fl, iv, rw, ld; int dr;
    int sv; int r0, r1, r2;
    bit chk_pre, e_stall; int e_fwd, e_cnt, e_infl;
  } vec_t;

  function automatic vec_t mk(bit rst, bit adv, bit fl, bit iv, bit rw, bit ld, int dr,
                              int sv, int r0, int r1, int r2,
                              bit chk_pre, bit e_stall, int e_fwd, int e_cnt, int e_infl);
    vec_t v;
    v.rst = rst; v.adv = adv; v.fl = fl; v.iv = iv; v.rw = rw; v.ld = ld; v.dr = dr;
    v.sv = sv; v.r0 = r0; v.r1 = r1; v.r2 = r2;
    v.chk_pre = chk_pre; v.e_stall = e_stall; v.e_fwd = e_fwd; v.e_cnt = e_cnt; v.e_infl = e_infl;
    return v;
  endfunction

  task automatic drive(input bit rst, input bit adv, input bit fl, input bit iv, input bit rw,
                       input bit ld, input int dr, input int sv, input int r0, input int r1,
                       input int r2);
    reset = rst; advance = adv; flush = fl;
    issue_valid = iv; issue_regwrite = rw; issue_is_load = ld; issue_dr = REG_W'(dr);
    src_valid = NUM_SRC'(sv);
    src_reg = {REG_W'(r2), REG_W'(r1), REG_W'(r0)};
  endtask

  // One clock: inputs already driven at the falling edge; model follows the edge.
  task automatic tick();
    m_step();
    @(posedge clk); #1;
    @(negedge clk);
  endtask

  vec_t tbl [20];

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    m_cnt = 0;
    for (int s = 0; s < NUM_SRC; s++) m_fwd[s] = 0;
    //            rst adv fl iv rw ld dr sv r0 r1 r2 pre stl fwd cnt infl
    tbl[0]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 0, 1, 1, 0, 3, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    tbl[2]  = mk(0, 1, 0, 1, 0, 0, 0, 1, 3, 0, 0, 1, 0, 1, 0, 1);
    tbl[3]  = mk(0, 1, 0, 1, 1, 0, 3, 0, 0, 0, 0, 1, 0, 0, 0, 2);
    tbl[4]  = mk(0, 1, 0, 1, 1, 0, 3, 0, 0, 0, 0, 1, 0, 0, 0, 2);
    tbl[5]  = mk(0, 1, 0, 0, 0, 0, 0, 2, 0, 3, 0, 1, 0, 4, 0, 2);
    tbl[6]  = mk(0, 1, 0, 1, 1, 1, 2, 0, 0, 0, 0, 1, 0, 0, 0, 2);
    tbl[7]  = mk(0, 1, 0, 1, 1, 0, 4, 1, 2, 0, 0, 1, 1, 0, 1, 1);
    tbl[8]  = mk(0, 1, 0, 1, 1, 0, 4, 1, 2, 0, 0, 1, 0, 2, 1, 2);
    tbl[9]  = mk(0, 1, 0, 1, 1, 1, 6, 0, 0, 0, 0, 1, 0, 0, 1, 2);
    tbl[10] = mk(0, 0, 0, 1, 1, 0, 7, 4, 0, 0, 6, 1, 1, 0, 1, 2);
    tbl[11] = mk(0, 0, 0, 1, 1, 0, 7, 4, 0, 0, 6, 1, 1, 0, 1, 2);
    tbl[12] = mk(0, 0, 0, 1, 1, 0, 7, 4, 0, 0, 6, 1, 1, 0, 1, 2);
    tbl[13] = mk(0, 1, 0, 1, 1, 0, 7, 4, 0, 0, 6, 1, 1, 0, 2, 2);
    tbl[14] = mk(0, 1, 0, 1, 1, 0, 5, 0, 0, 0, 0, 1, 0, 0, 2, 2);
    tbl[15] = mk(0, 1, 1, 1, 1, 0, 1, 1, 5, 0, 0, 1, 0, 0, 2, 1);
    tbl[16] = mk(0, 1, 0, 1, 1, 1, 1, 0, 0, 0, 0, 1, 0, 0, 2, 2);
    tbl[17] = mk(0, 1, 1, 1, 1, 0, 4, 1, 1, 0, 0, 1, 1, 0, 2, 1);
    tbl[18] = mk(0, 1, 0, 0, 0, 0, 0, 3, 1, 1, 0, 1, 0, 10, 2, 1);
    tbl[19] = mk(0, 0, 1, 1, 1, 0, 2, 0, 0, 0, 0, 1, 0, 10, 2, 1);

    @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      drive(tbl[k].rst, tbl[k].adv, tbl[k].fl, tbl[k].iv, tbl[k].rw, tbl[k].ld,
            tbl[k].dr, tbl[k].sv, tbl[k].r0, tbl[k].r1, tbl[k].r2);
      #1;
      if (tbl[k].chk_pre) chk($sformatf("tbl%0d_stall", k), load_use_stall, tbl[k].e_stall);
      m_step();
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_fwd", k), fwd_sel, tbl[k].e_fwd);
      chk($sformatf("tbl%0d_cnt", k), stall_count, tbl[k].e_cnt);
      chk($sformatf("tbl%0d_infl", k), inflight, tbl[k].e_infl);
      @(negedge clk);
    end

    // Mid-stream reset: build stall_count=7 and three live writers, then reset.
    for (int p = 0; p < 5; p++) begin
      drive(0, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0);
      tick();
      drive(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      #1 chk("ms_stall", load_use_stall, 1);
      tick();
    end
    chk("ms_cnt7", stall_count, 7);
    for (int w = 1; w <= 3; w++) begin
      drive(0, 1, 0, 1, 1, 0, w, 0, 0, 0, 0);
      tick();
    end
    chk("ms_infl3", inflight, 3);
    drive(1, 1, 0, 1, 1, 1, 4, 7, 3, 3, 3);
    tick();
    chk("ms_rst_infl", inflight, 0);
    chk("ms_rst_cnt", stall_count, 0);
    chk("ms_rst_fwd", fwd_sel, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 7, 3, 2, 1);
    #1 chk("ms_post_stall", load_use_stall, 0);
    tick();
    chk("ms_post_fwd", fwd_sel, 0);

    // Random traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 7) != 0),
            ($urandom_range(0, 9) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 7),
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      #1;
      m_eval();
      chk("rnd_stall", load_use_stall, m_stall);
      chk("rnd_infl_pre", inflight, m_inflight());
      m_step();
      @(posedge clk); #1;
      chk("rnd_fwd", fwd_sel, m_fwd_packed());
      chk("rnd_cnt", stall_count, m_cnt);
      chk("rnd_infl", inflight, m_inflight());
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
